// File: rtl/dram_sram16_bridge_if.sv
// rtl/dram_sram16_bridge_if.sv - MCU-side DRAM request/response bus of the 16-bit SRAM bridge
interface dram_sram16_bridge_if #(
  parameter int MEM_ADDR_BITS = 16
);
  logic [MEM_ADDR_BITS-1:0] dram_mem_addr;
  logic                     dram_mem_read_en;
  logic                     dram_mem_write_en;
  logic [3:0]               dram_mem_byte_enable;
  logic [31:0]              dram_mem_write_data;
  logic                     dram_ack;
  logic [31:0]              dram_mem_read_data;

  // MCU side issues strobes and consumes the ack/read word
  modport master (
    output dram_mem_addr, dram_mem_read_en, dram_mem_write_en,
    output dram_mem_byte_enable, dram_mem_write_data,
    input  dram_ack, dram_mem_read_data
  );

  // Bridge side
  modport slave (
    input  dram_mem_addr, dram_mem_read_en, dram_mem_write_en,
    input  dram_mem_byte_enable, dram_mem_write_data,
    output dram_ack, dram_mem_read_data
  );
endinterface

// File: rtl/dram_sram16_bridge.sv
// rtl/dram_sram16_bridge.sv - 32-bit MCU word access split into two 16-bit async SRAM accesses
module dram_sram16_bridge #(
  parameter int MEM_ADDR_BITS = 16,
  parameter int WAIT_CYCLES   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dram_sram16_bridge_if.slave    dram,
  output logic                   busy,
  output logic                   req_dropped,
  output logic [MEM_ADDR_BITS:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n
);

  typedef enum logic [2:0] {
    IDLE, SETUP_LO, STROBE_LO, SETUP_HI, STROBE_HI, DONE
  } state_t;

  localparam logic [3:0] STROBE_LEN = 4'(WAIT_CYCLES);

  state_t                   state;
  logic [MEM_ADDR_BITS-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [3:0]               be_q;
  logic                     wr_q;
  logic [3:0]               cnt;
  logic [31:0]              rd_buf;
  logic                     req;

  assign req = dram.dram_mem_read_en | dram.dram_mem_write_en;

  // Reads always drive both byte lanes; writes enable only the requested bytes
  function automatic logic [1:0] lanes_n(input logic wr, input logic [1:0] be);
    return wr ? ~be : 2'b00;
  endfunction

  // Request sequencer: every SRAM control is registered on the transition into its state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state                   <= IDLE;
      addr_q                  <= '0;
      wdata_q                 <= '0;
      be_q                    <= '0;
      wr_q                    <= 1'b0;
      cnt                     <= '0;
      rd_buf                  <= '0;
      busy                    <= 1'b0;
      req_dropped             <= 1'b0;
      dram.dram_ack           <= 1'b0;
      dram.dram_mem_read_data <= '0;
      sram_addr               <= '0;
      sram_dq_out             <= '0;
      sram_dq_oe              <= 1'b0;
      sram_ce_n               <= 1'b1;
      sram_oe_n               <= 1'b1;
      sram_we_n               <= 1'b1;
      sram_ub_n               <= 1'b1;
      sram_lb_n               <= 1'b1;
    end else begin
      dram.dram_ack <= 1'b0;
      if (state != IDLE && req) req_dropped <= 1'b1;

      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= dram.dram_mem_addr;
            wdata_q <= dram.dram_mem_write_data;
            be_q    <= dram.dram_mem_byte_enable;
            wr_q    <= dram.dram_mem_write_en;
            busy    <= 1'b1;
            if (!dram.dram_mem_write_en || (|dram.dram_mem_byte_enable[1:0])) begin
              state                  <= SETUP_LO;
              sram_ce_n              <= 1'b0;
              sram_addr              <= {dram.dram_mem_addr, 1'b0};
              sram_dq_oe             <= dram.dram_mem_write_en;
              sram_dq_out            <= dram.dram_mem_write_data[15:0];
              {sram_ub_n, sram_lb_n} <= lanes_n(dram.dram_mem_write_en,
                                                dram.dram_mem_byte_enable[1:0]);
            end else if (|dram.dram_mem_byte_enable[3:2]) begin
              state                  <= SETUP_HI;
              sram_ce_n              <= 1'b0;
              sram_addr              <= {dram.dram_mem_addr, 1'b1};
              sram_dq_oe             <= 1'b1;
              sram_dq_out            <= dram.dram_mem_write_data[31:16];
              {sram_ub_n, sram_lb_n} <= lanes_n(1'b1, dram.dram_mem_byte_enable[3:2]);
            end else begin
              // Write with no enabled bytes: nothing to do on the SRAM
              state <= DONE;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        SETUP_LO, SETUP_HI: begin
          state     <= (state == SETUP_LO) ? STROBE_LO : STROBE_HI;
          cnt       <= STROBE_LEN;
          sram_we_n <= ~wr_q;
          sram_oe_n <= wr_q;
        end

        STROBE_LO, STROBE_HI: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last strobe cycle: the SRAM output has settled for the full strobe width
            if (!wr_q) begin
              if (state == STROBE_LO) rd_buf[15:0]  <= sram_dq_in;
              else                    rd_buf[31:16] <= sram_dq_in;
            end
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (state == STROBE_LO && (!wr_q || (|be_q[3:2]))) begin
              state                  <= SETUP_HI;
              sram_addr              <= {addr_q, 1'b1};
              sram_dq_out            <= wdata_q[31:16];
              {sram_ub_n, sram_lb_n} <= lanes_n(wr_q, be_q[3:2]);
            end else begin
              state      <= DONE;
              sram_ce_n  <= 1'b1;
              sram_ub_n  <= 1'b1;
              sram_lb_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end
          end
        end

        DONE: begin
          dram.dram_ack <= 1'b1;
          if (!wr_q) dram.dram_mem_read_data <= rd_buf;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_sram16_bridge.sv
// tb/tb_dram_sram16_bridge.sv - scoreboard bench for the 16-bit SRAM bridge
module tb_dram_sram16_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        use_w0;
  logic [15:0] m_addr;
  logic        m_rd, m_wr;
  logic [3:0]  m_be;
  logic [31:0] m_wd;

  dram_sram16_bridge_if #(.MEM_ADDR_BITS(16)) bus2 ();
  dram_sram16_bridge_if #(.MEM_ADDR_BITS(16)) bus0 ();

  assign bus2.dram_mem_addr        = m_addr;
  assign bus2.dram_mem_read_en     = m_rd & ~use_w0;
  assign bus2.dram_mem_write_en    = m_wr & ~use_w0;
  assign bus2.dram_mem_byte_enable = m_be;
  assign bus2.dram_mem_write_data  = m_wd;
  assign bus0.dram_mem_addr        = m_addr;
  assign bus0.dram_mem_read_en     = m_rd & use_w0;
  assign bus0.dram_mem_write_en    = m_wr & use_w0;
  assign bus0.dram_mem_byte_enable = m_be;
  assign bus0.dram_mem_write_data  = m_wd;

  logic        busy2, drop2, dqoe2, ce2, oe2, we2, ub2, lb2;
  logic [16:0] sa2;
  logic [15:0] dqo2, dqi2;
  logic        busy0, drop0, dqoe0, ce0, oe0, we0, ub0, lb0;
  logic [16:0] sa0;
  logic [15:0] dqo0, dqi0;

  dram_sram16_bridge #(.MEM_ADDR_BITS(16), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n), .dram(bus2), .busy(busy2), .req_dropped(drop2),
    .sram_addr(sa2), .sram_dq_out(dqo2), .sram_dq_oe(dqoe2), .sram_dq_in(dqi2),
    .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2), .sram_ub_n(ub2), .sram_lb_n(lb2)
  );

  dram_sram16_bridge #(.MEM_ADDR_BITS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .dram(bus0), .busy(busy0), .req_dropped(drop0),
    .sram_addr(sa0), .sram_dq_out(dqo0), .sram_dq_oe(dqoe0), .sram_dq_in(dqi0),
    .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0), .sram_ub_n(ub0), .sram_lb_n(lb0)
  );

  // SRAM models with a backdoor preload port
  logic [15:0] mem2 [0:255];
  logic [15:0] mem0 [0:255];
  logic        bd_we, bd_sel;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we && !bd_sel) mem2[bd_addr] <= bd_data;
    else if (!ce2 && !we2) begin
      if (!ub2) mem2[sa2[7:0]][15:8] <= dqo2[15:8];
      if (!lb2) mem2[sa2[7:0]][7:0]  <= dqo2[7:0];
    end
  end

  always @(posedge clk) begin
    if (bd_we && bd_sel) mem0[bd_addr] <= bd_data;
    else if (!ce0 && !we0) begin
      if (!ub0) mem0[sa0[7:0]][15:8] <= dqo0[15:8];
      if (!lb0) mem0[sa0[7:0]][7:0]  <= dqo0[7:0];
    end
  end

  assign dqi2 = mem2[sa2[7:0]];
  assign dqi0 = mem0[sa0[7:0]];

  // Observed view of whichever instance is under test
  logic        ack_o, busy_o, drop_o, dqoe_o, ce_o, oe_o, we_o, ub_o, lb_o;
  logic [31:0] rd_o;
  logic [16:0] sa_o;
  assign ack_o  = use_w0 ? bus0.dram_ack           : bus2.dram_ack;
  assign rd_o   = use_w0 ? bus0.dram_mem_read_data : bus2.dram_mem_read_data;
  assign busy_o = use_w0 ? busy0 : busy2;
  assign drop_o = use_w0 ? drop0 : drop2;
  assign sa_o   = use_w0 ? sa0   : sa2;
  assign dqoe_o = use_w0 ? dqoe0 : dqoe2;
  assign ce_o   = use_w0 ? ce0   : ce2;
  assign oe_o   = use_w0 ? oe0   : oe2;
  assign we_o   = use_w0 ? we0   : we2;
  assign ub_o   = use_w0 ? ub0   : ub2;
  assign lb_o   = use_w0 ? lb0   : lb2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
    int          lat;
    int          lo;
    int          hi;
    int          setups;
    logic [1:0]  lanes;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0, n_miss = 0;
  int          t0, n_lo, n_hi, n_setup, n_bad, n_acks;
  logic [1:0]  lanes_seen;
  logic [15:0] cur_addr;
  logic        cur_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic is_rd, input logic [31:0] d, input int lat,
                              input int lo, input int hi, input int su, input logic [1:0] ln);
    exp_t e;
    e.is_rd = is_rd; e.data = d; e.lat = lat;
    e.lo = lo; e.hi = hi; e.setups = su; e.lanes = ln;
    return e;
  endfunction

  // Watches the SRAM pins and pops the scoreboard on every ack
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (!ce_o && (!oe_o || !we_o)) begin
          if (sa_o[0]) n_hi++; else n_lo++;
          if (sa_o[16:1] != cur_addr) n_bad++;
          if (cur_wr ? (!oe_o || !dqoe_o) : !we_o) n_bad++;
          lanes_seen = {ub_o, lb_o};
        end else if (!ce_o) begin
          n_setup++;
        end
        if (ack_o) begin
          n_acks++;
          check("ack_pending", 32'(sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("latency", cyc - t0 - 1, e.lat);
            check("lo_strobes", n_lo, e.lo);
            check("hi_strobes", n_hi, e.hi);
            check("setups", n_setup, e.setups);
            check("strobe_ok", n_bad, 0);
            check("lanes", lanes_seen, e.lanes);
            if (e.is_rd) check("rdata", rd_o, e.data);
          end
        end
      end
    end
  endtask

  task automatic bd_write(input logic sel, input logic [7:0] a, input logic [15:0] d);
    bd_sel = sel; bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input exp_t e, input int inj);
    int start;
    start = n_acks;
    @(posedge clk); #1;
    sbq.push_back(e);
    t0 = cyc; n_lo = 0; n_hi = 0; n_setup = 0; n_bad = 0; lanes_seen = 2'b11;
    cur_addr = a; cur_wr = wr;
    m_rd = rd; m_wr = wr; m_addr = a; m_be = be; m_wd = wd;
    @(posedge clk); #1;
    m_rd = 1'b0; m_wr = 1'b0;
    check("busy_set", busy_o, 1);
    for (int k = 1; k <= 60; k++) begin
      if (n_acks != start) break;
      if (k == inj) m_rd = 1'b1;
      if (k == inj + 1) m_rd = 1'b0;
      @(posedge clk); #1;
    end
    check("ack_seen", 32'(n_acks != start), 1);
    check("busy_clr", busy_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; use_w0 = 1'b0; bd_we = 1'b0; bd_sel = 1'b0; bd_addr = '0; bd_data = '0;
    m_addr = '0; m_rd = 1'b0; m_wr = 1'b0; m_be = '0; m_wd = '0;
    cur_addr = '0; cur_wr = 1'b0; t0 = 0; n_acks = 0;
    n_lo = 0; n_hi = 0; n_setup = 0; n_bad = 0; lanes_seen = 2'b11;
    fork monitor(); join_none

    bd_write(1'b0, 8'h20, 16'hBEEF);
    bd_write(1'b0, 8'h21, 16'hDEAD);
    bd_write(1'b0, 8'h0A, 16'h2222);
    bd_write(1'b0, 8'h0B, 16'h1111);
    bd_write(1'b0, 8'h0C, 16'h3333);
    bd_write(1'b1, 8'h20, 16'h5A5A);
    bd_write(1'b1, 8'h21, 16'hA5A5);

    check("rst_ctl", {27'd0, ce_o, oe_o, we_o, ub_o, lb_o}, 32'h1F);
    check("rst_dq", {15'd0, dqoe_o, dqo2}, 0);
    check("rst_addr", sa_o, 0);
    check("rst_mcu", {ack_o, busy_o, drop_o}, 0);
    check("rst_rdata", rd_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full read, full write, single-half writes, empty write
    req(1, 0, 16'h0010, 4'h0, 32'h0, mk(1, 32'hDEADBEEF, 9, 3, 3, 2, 2'b00), 0);
    req(0, 1, 16'h0003, 4'hF, 32'h12345678, mk(0, 0, 9, 3, 3, 2, 2'b00), 0);
    check("mem_06", mem2[6], 16'h5678);
    check("mem_07", mem2[7], 16'h1234);
    check("rdata_hold", rd_o, 32'hDEADBEEF);
    req(0, 1, 16'h0005, 4'h4, 32'hAABBCCDD, mk(0, 0, 5, 0, 3, 1, 2'b10), 0);
    check("mem_0b", mem2[8'h0B], 16'h11BB);
    check("mem_0a", mem2[8'h0A], 16'h2222);
    req(0, 1, 16'h0006, 4'h2, 32'h00009900, mk(0, 0, 5, 3, 0, 1, 2'b01), 0);
    check("mem_0c", mem2[8'h0C], 16'h9933);
    req(0, 1, 16'h0007, 4'h0, 32'hFFFFFFFF, mk(0, 0, 1, 0, 0, 0, 2'b11), 0);
    check("drop_clear", drop_o, 0);

    // Strobe mid-read is dropped and sticks
    req(1, 0, 16'h0010, 4'h0, 32'h0, mk(1, 32'hDEADBEEF, 9, 3, 3, 2, 2'b00), 3);
    check("drop_set", drop_o, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("drop_sticky", drop_o, 1);

    // Reset during the high-half strobe of a write
    cur_addr = 16'h0040; cur_wr = 1'b1;
    m_addr = 16'h0040; m_be = 4'hF; m_wd = 32'h0BADF00D; m_wr = 1'b1;
    @(posedge clk); #1;
    m_wr = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("mid_strobe_hi", {sa_o[0], we_o}, 2'b10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ctl", {27'd0, ce_o, oe_o, we_o, ub_o, lb_o}, 32'h1F);
    check("abort_dq_oe", dqoe_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_ack", ack_o, 0);
    check("abort_drop", drop_o, 0);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    req(1, 0, 16'h0010, 4'h0, 32'h0, mk(1, 32'hDEADBEEF, 9, 3, 3, 2, 2'b00), 0);

    // Zero wait states; simultaneous strobes resolve to a write
    use_w0 = 1'b1;
    req(1, 0, 16'h0010, 4'h0, 32'h0, mk(1, 32'hA5A55A5A, 5, 1, 1, 2, 2'b00), 0);
    req(1, 1, 16'h0008, 4'hF, 32'hCAFEF00D, mk(0, 0, 5, 1, 1, 2, 2'b00), 0);
    check("w0_mem_10", mem0[8'h10], 16'hF00D);
    check("w0_mem_11", mem0[8'h11], 16'hCAFE);
    check("w0_drop", drop_o, 0);
    check("w0_rdata_hold", rd_o, 32'hA5A55A5A);

    repeat (3) begin @(posedge clk); #1; end
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dram_sram16_bridge.md
Name: dram_sram16_bridge

Overview:
- Downstream of the MCU external-memory port. Consumes the MCU's single-cycle DRAM read/write strobes and produces the dram_ack / read-data response.
- Executes each 32-bit word access as two 16-bit accesses on an external asynchronous SRAM, with a programmable strobe width.
- Byte enables map to SRAM UB/LB. Halfword writes with no enabled bytes are skipped.

Parameters:
- MEM_ADDR_BITS, 16, width of the MCU word address.
- WAIT_CYCLES, 2, extra strobe cycles per halfword access. Strobe width = WAIT_CYCLES+1 cycles. Range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dram_mem_addr  in  MEM_ADDR_BITS  word address from MCU.
- dram_mem_read_en  in  1  read request strobe.
- dram_mem_write_en  in  1  write request strobe.
- dram_mem_byte_enable  in  4  write byte lanes; bit0 = bits 7:0.
- dram_mem_write_data  in  32  write word.
- dram_ack  out  1  one-cycle completion pulse (read or write).
- dram_mem_read_data  out  32  read word; valid while dram_ack=1, held until the next read completes.
- busy  out  1  high from acceptance through the ack cycle.
- req_dropped  out  1  sticky: a strobe arrived while not IDLE; cleared only by reset.
- sram_addr  out  MEM_ADDR_BITS+1  {word addr, half}; half 0 = bits 15:0.
- sram_dq_out  out  16  write data.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  16  read data.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM controls.

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at an edge):
  - sram_ce_n/oe_n/we_n/ub_n/lb_n = 1.
  - sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0.
  - dram_ack = 0; dram_mem_read_data = 0; busy = 0; req_dropped = 0.
  - FSM goes to IDLE.
  - Reset mid-transaction abandons the transaction with no ack and no partial-write guarantee.
- FSM states: IDLE, SETUP_LO, STROBE_LO, SETUP_HI, STROBE_HI, DONE.
- IDLE:
  - Accepts a request on any cycle with read_en|write_en = 1.
  - Latches addr, write data, enables and op. Sets busy.
  - Write wins if both strobes are high; the read is ignored and req_dropped is not set.
- Halfword needs:
  - Read: both halves always, with ub_n = lb_n = 0.
  - Write: lo half needed iff byte_enable[1:0] != 0; hi half needed iff byte_enable[3:2] != 0.
  - Write ub_n/lb_n = inverted enable bits of that half.
- Next state from IDLE:
  - SETUP_LO if the lo half is needed.
  - Else SETUP_HI if the hi half is needed.
  - Else DONE (write with byte_enable = 0).
- SETUP_x (1 cycle):
  - ce_n = 0; sram_addr = {addr, x}; we_n = 1; oe_n = 1.
  - For writes: dq_oe = 1 and dq_out = that halfword.
- STROBE_x (WAIT_CYCLES+1 cycles, counted by a down-counter):
  - Address and data held.
  - Read: oe_n = 0. Write: we_n = 0, dq_oe = 1.
  - Read data: sram_dq_in is captured on the last strobe cycle into the lo/hi half of the read register.
- Leaving STROBE_LO: go to SETUP_HI if the hi half is needed, else DONE.
- Leaving STROBE_HI: go to DONE.
- DONE (1 cycle):
  - All SRAM controls inactive; dq_oe = 0.
  - dram_ack = 1. For reads, dram_mem_read_data is updated in this same cycle.
  - busy deasserts the next cycle; return to IDLE.
- A new request can be accepted in the cycle after DONE.
- Latency (acceptance edge T to dram_ack), W = WAIT_CYCLES:
  - Read / full write: 2(W+2)+1.
  - Single-half write: W+3.
  - Zero-enable write: 1.
- Strobes seen in any non-IDLE state are ignored and set req_dropped; the current transaction is unaffected.
- Writes never modify dram_mem_read_data.
- Address width: no wrap is required; sram_addr MSBs = dram_mem_addr.

Test Plan:
- W=2, read addr 0x0010; SRAM model holds half0 = 0xBEEF, half1 = 0xDEAD at 0x0020/0x0021 -> sram_addr 0x0020 then 0x0021, oe_n low 3 cycles each; dram_ack exactly 9 cycles after the strobe; read_data = 0xDEADBEEF.
- W=2, write addr 0x0003, data 0x12345678, BE=0xF -> SRAM 0x0006 = 0x5678, 0x0007 = 0x1234; we_n low 3 cycles per half, with a 1-cycle setup before each half; ack after 9 cycles.
- Write BE=0x4, data 0xAABBCCDD -> only hi half accessed, ub_n=1, lb_n=0, byte 0xBB written; ack after 5 cycles. BE=0x0 -> no SRAM activity, ack after 1 cycle.
- Second strobe 3 cycles into a read -> req_dropped=1 (sticky), first read completes normally, exactly one ack.
- reset_n=0 during STROBE_HI of a write -> next edge all controls inactive, dq_oe=0, busy=0, no ack. A following read then completes normally.
- W=0: read latency 5 cycles. Simultaneous read_en+write_en -> write performed, req_dropped stays 0.
